wptr_ctrl: RTL

Write-side pointer and flag controller for the asynchronous/synchronous FIFO family. It is a parametrised successor to the basic write-pointer handler. It keeps binary and Gray write pointers, and derives registered full, programmable almost-full and a write-side occupancy count from a Gray read pointer that has already been synchronised. It sits in the write clock domain, between the producer and the dual-port RAM write port.

---
 rtl/wptr_ctrl.sv | 62 ++++++
 1 files changed

// File: rtl/wptr_ctrl.sv
// wptr_ctrl: write-side pointer/flag controller (optional sticky overflow via WPTR_OVF_EN)
module wptr_ctrl #(
    parameter int PTR_WIDTH = 3,
    parameter int AF_LEVEL  = 6
) (
    input  logic                 wclk,
    input  logic                 wrst,
    input  logic                 w_en,
    input  logic [PTR_WIDTH:0]   g_rptr_sync,
    input  logic                 ovf_clr,
    output logic                 w_accept,
    output logic [PTR_WIDTH-1:0] waddr,
    output logic [PTR_WIDTH:0]   b_wptr,
    output logic [PTR_WIDTH:0]   g_wptr,
    output logic                 full,
    output logic                 almost_full,
    output logic [PTR_WIDTH:0]   wlevel,
    output logic                 overflow
);
    localparam logic [PTR_WIDTH:0] DEPTH_W = (PTR_WIDTH+1)'(1 << PTR_WIDTH);
    localparam logic [PTR_WIDTH:0] AF_W    = (PTR_WIDTH+1)'(AF_LEVEL);
    logic               accept;
    logic [PTR_WIDTH:0] b_next, g_next, rbin, level_next;
    // next pointers and occupancy; read pointer decoded from Gray by MSB-down XOR prefix
    always_comb begin
        accept     = w_en & ~full;
        b_next     = b_wptr + {{PTR_WIDTH{1'b0}}, accept};
        g_next     = b_next ^ (b_next >> 1);
        rbin       = g_rptr_sync;
        for (int i = PTR_WIDTH - 1; i >= 0; i--) rbin[i] = rbin[i+1] ^ g_rptr_sync[i];
        level_next = b_next - rbin;
    end
    assign w_accept = accept & ~wrst;
    assign waddr    = b_wptr[PTR_WIDTH-1:0];
    // pointers and flags recomputed every cycle so flags track the read side without writes
    always_ff @(posedge wclk) begin
        if (wrst) begin
            b_wptr      <= '0;
            g_wptr      <= '0;
            wlevel      <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
        end else begin
            b_wptr      <= b_next;
            g_wptr      <= g_next;
            wlevel      <= level_next;
            full        <= level_next >= DEPTH_W;
            almost_full <= level_next >= AF_W;
        end
    end
`ifdef WPTR_OVF_EN
    // sticky overflow: a dropped write beats a clear in the same cycle
    always_ff @(posedge wclk) begin
        if (wrst) overflow <= 1'b0;
        else overflow <= (w_en & full) ? 1'b1 : (ovf_clr ? 1'b0 : overflow);
    end
`else
    logic unused_ovf_clr;
    assign unused_ovf_clr = ovf_clr;
    assign overflow       = 1'b0;
`endif
endmodule
